// File: rtl/store_mmio_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : store_mmio_unit_pkg
// Brief   : Shared constants for the store/MMIO path: opcodes, MMIO offsets,
//           region nibbles and the UART TX holding-register state encoding.
// Rev     : 1.0
// ============================================================================
package store_mmio_unit_pkg;

  localparam logic [6:0] c_OPC_STORE = 7'b0100011;

  localparam logic [2:0] c_F3_SB = 3'b000;
  localparam logic [2:0] c_F3_SH = 3'b001;
  localparam logic [2:0] c_F3_SW = 3'b010;

  localparam logic [3:0] c_IO_BASE = 4'h8;

  localparam logic [7:0] c_OFF_UART_TX = 8'h08;
  localparam logic [7:0] c_OFF_CYC     = 8'h10;
  localparam logic [7:0] c_OFF_INST    = 8'h14;
  localparam logic [7:0] c_OFF_CNT_RST = 8'h18;

  typedef enum logic [0:0] {
    TX_EMPTY = 1'b0,
    TX_FULL  = 1'b1
  } tx_state_e;

  // DMEM lives in regions 4'b00x1, IMEM in 4'b001x (0x3 is visible in both).
  function automatic logic is_dmem_region(input logic [3:0] nib);
    return (nib[3:2] == 2'b00) && nib[0];
  endfunction

  function automatic logic is_imem_region(input logic [3:0] nib);
    return nib[3:1] == 3'b001;
  endfunction

endpackage
`default_nettype wire

// File: rtl/store_lane_shaper.sv
`default_nettype none
// ============================================================================
// Module  : store_lane_shaper
// Brief   : Combinational byte-lane mask, replicated write data and
//           misalignment flag for SB/SH/SW.
// Rev     : 1.0
// ============================================================================
module store_lane_shaper
  import store_mmio_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rs2,
  output logic [3:0]  mask,
  output logic [31:0] wdata,
  output logic        misalign
);

  always_comb begin
    mask     = 4'b0000;
    wdata    = rs2;
    misalign = 1'b0;
    case (funct3)
      c_F3_SB: begin
        mask  = 4'b0001 << addr_lo;
        wdata = {4{rs2[7:0]}};
      end
      c_F3_SH: begin
        wdata = {2{rs2[15:0]}};
        if (addr_lo[0]) begin
          misalign = 1'b1;
        end else begin
          mask = 4'b0011 << {addr_lo[1], 1'b0};
        end
      end
      c_F3_SW: begin
        if (addr_lo != 2'b00) begin
          misalign = 1'b1;
        end else begin
          mask = 4'b1111;
        end
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/store_mmio_unit.sv
`default_nettype none
// ============================================================================
// Module  : store_mmio_unit
// Brief   : Execute-stage store decode (DMEM/IMEM byte enables), UART TX
//           holding register and cycle/instruction counters.
//           Optional: COUNTER_SATURATE_EN makes counters saturate, not wrap.
// Rev     : 1.0
// ============================================================================
module store_mmio_unit
  import store_mmio_unit_pkg::*;
#(
  parameter logic [3:0] IO_BASE = c_IO_BASE,
  parameter int         CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       inst_ex,
  input  logic [31:0]       addr,
  input  logic [31:0]       rs2_data,
  input  logic [31:0]       pc_ex,
  input  logic              pipe_stall,
  input  logic              retire,
  output logic [3:0]        dmem_we,
  output logic [3:0]        imem_we,
  output logic [31:0]       mem_wdata,
  output logic [7:0]        uart_tx_data,
  output logic              uart_tx_valid,
  input  logic              uart_tx_ready,
  output logic [CNT_W-1:0]  cycle_count,
  output logic [CNT_W-1:0]  inst_count,
  output logic              stall_req,
  output logic              misalign
);

  tx_state_e         r_tx_state;
  tx_state_e         w_tx_next;
  logic [7:0]        r_tx_data;
  logic [CNT_W-1:0]  r_cycle;
  logic [CNT_W-1:0]  r_inst;

  logic [3:0]        w_mask;
  logic              w_shape_misalign;
  logic              w_is_store;
  logic              w_io;
  logic              w_tx_hit;
  logic              w_active;
  logic              w_tx_store;
  logic              w_cnt_rst;
  logic              w_inst_inc;
  logic              w_unused_bits;

  store_lane_shaper u_shaper (
    .funct3   (inst_ex[14:12]),
    .addr_lo  (addr[1:0]),
    .rs2      (rs2_data),
    .mask     (w_mask),
    .wdata    (mem_wdata),
    .misalign (w_shape_misalign)
  );

  assign w_is_store = (inst_ex[6:0] == c_OPC_STORE);
  assign w_io       = (addr[31:28] == IO_BASE);
  assign w_tx_hit   = w_is_store && w_io && (addr[7:0] == c_OFF_UART_TX);

  // A TX store can only be blocked by a full register the transmitter refuses.
  assign stall_req  = w_tx_hit && (r_tx_state == TX_FULL) && !uart_tx_ready;
  assign w_active   = w_is_store && !pipe_stall && !stall_req;
  assign w_tx_store = w_active && w_tx_hit;
  assign w_cnt_rst  = w_active && w_io && (addr[7:0] == c_OFF_CNT_RST);
  assign w_inst_inc = retire && !pipe_stall;

  assign misalign = w_is_store && w_shape_misalign;
  assign dmem_we  = (w_active && !w_io && is_dmem_region(addr[31:28])) ? w_mask : 4'b0000;
  assign imem_we  = (w_active && !w_io && is_imem_region(addr[31:28]) && pc_ex[30])
                    ? w_mask : 4'b0000;

  assign uart_tx_valid = (r_tx_state == TX_FULL);
  assign uart_tx_data  = r_tx_data;
  assign cycle_count   = r_cycle;
  assign inst_count    = r_inst;

  assign w_unused_bits = ^{inst_ex[31:15], inst_ex[11:7], addr[27:8],
                           pc_ex[31], pc_ex[29:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_state <= TX_EMPTY;
    end else begin
      r_tx_state <= w_tx_next;
    end
  end

  // A new TX store in FULL only gets through when ready is high, so it
  // always coincides with a handshake and the register stays FULL.
  always_comb begin
    w_tx_next = r_tx_state;
    case (r_tx_state)
      TX_EMPTY: if (w_tx_store) w_tx_next = TX_FULL;
      TX_FULL:  if (!w_tx_store && uart_tx_ready) w_tx_next = TX_EMPTY;
      default:  w_tx_next = TX_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tx_data <= 8'h00;
    end else if (w_tx_store) begin
      r_tx_data <= rs2_data[7:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || w_cnt_rst) begin
      r_cycle <= '0;
      r_inst  <= '0;
    end else begin
`ifdef COUNTER_SATURATE_EN
      if (!(&r_cycle)) r_cycle <= r_cycle + CNT_W'(1);
      if (w_inst_inc && !(&r_inst)) r_inst <= r_inst + CNT_W'(1);
`else
      r_cycle <= r_cycle + CNT_W'(1);
      if (w_inst_inc) r_inst <= r_inst + CNT_W'(1);
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_store_mmio_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_store_mmio_unit
// Brief   : Directed self-checking bench for store_mmio_unit.
// Rev     : 1.0
// ============================================================================
module tb_store_mmio_unit;

  localparam logic [31:0] c_NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] inst_ex, addr, rs2_data, pc_ex;
  logic        pipe_stall, retire, uart_tx_ready;

  logic [3:0]  dmem_we, imem_we;
  logic [31:0] mem_wdata;
  logic [7:0]  uart_tx_data;
  logic        uart_tx_valid, stall_req, misalign;
  logic [31:0] cycle_count, inst_count;

  logic [3:0]  d4_dmem_we, d4_imem_we;
  logic [31:0] d4_mem_wdata;
  logic [7:0]  d4_uart_tx_data;
  logic        d4_uart_tx_valid, d4_stall_req, d4_misalign;
  logic [3:0]  d4_cycle_count, d4_inst_count;

  int n_vec = 0;
  int n_miscmp = 0;

  always #5 clk = ~clk;

  store_mmio_unit u_dut (
    .clk(clk), .rst_n(rst_n), .inst_ex(inst_ex), .addr(addr), .rs2_data(rs2_data),
    .pc_ex(pc_ex), .pipe_stall(pipe_stall), .retire(retire), .dmem_we(dmem_we),
    .imem_we(imem_we), .mem_wdata(mem_wdata), .uart_tx_data(uart_tx_data),
    .uart_tx_valid(uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .cycle_count(cycle_count), .inst_count(inst_count), .stall_req(stall_req),
    .misalign(misalign)
  );

  store_mmio_unit #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .inst_ex(inst_ex), .addr(addr), .rs2_data(rs2_data),
    .pc_ex(pc_ex), .pipe_stall(pipe_stall), .retire(retire), .dmem_we(d4_dmem_we),
    .imem_we(d4_imem_we), .mem_wdata(d4_mem_wdata), .uart_tx_data(d4_uart_tx_data),
    .uart_tx_valid(d4_uart_tx_valid), .uart_tx_ready(uart_tx_ready),
    .cycle_count(d4_cycle_count), .inst_count(d4_inst_count), .stall_req(d4_stall_req),
    .misalign(d4_misalign)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscmp++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] st(input logic [2:0] f3);
    return {17'd0, f3, 5'd0, 7'b0100011};
  endfunction

  task automatic drive(input logic [31:0] i, input logic [31:0] a,
                       input logic [31:0] d, input logic [31:0] pc);
    inst_ex = i; addr = a; rs2_data = d; pc_ex = pc;
    #1;
  endtask

  task automatic idle();
    inst_ex = c_NOP; addr = 32'h0; rs2_data = 32'h0; pc_ex = 32'h0;
  endtask

  initial begin
    int guard;
    logic [3:0] exp4;
    rst_n = 1'b0; pipe_stall = 1'b0; retire = 1'b0; uart_tx_ready = 1'b0;
    idle();
    tick(); tick();
    check_eq("rst_valid", {31'd0, uart_tx_valid}, 32'd0);
    check_eq("rst_data",  {24'd0, uart_tx_data}, 32'd0);
    check_eq("rst_cyc",   cycle_count, 32'd0);
    check_eq("rst_inst",  inst_count, 32'd0);
    rst_n = 1'b1;

    // Lane shaping and address decode
    drive(st(3'b000), 32'h1000_0003, 32'h0000_00A5, 32'h0);
    check_eq("sb_dmem",  {28'd0, dmem_we}, 32'h8);
    check_eq("sb_wdata", mem_wdata, 32'hA5A5_A5A5);
    check_eq("sb_imem",  {28'd0, imem_we}, 32'h0);
    check_eq("sb_mis",   {31'd0, misalign}, 32'd0);
    drive(st(3'b001), 32'h1000_0001, 32'h0000_1234, 32'h0);
    check_eq("sh_mis_dmem", {28'd0, dmem_we}, 32'h0);
    check_eq("sh_mis_flag", {31'd0, misalign}, 32'd1);
    drive(st(3'b001), 32'h1000_0002, 32'h1234_BEEF, 32'h0);
    check_eq("sh_dmem",  {28'd0, dmem_we}, 32'hC);
    check_eq("sh_wdata", mem_wdata, 32'hBEEF_BEEF);
    drive(st(3'b010), 32'h2000_0000, 32'hDEAD_BEEF, 32'h4000_0000);
    check_eq("sw_imem_pc30", {28'd0, imem_we}, 32'hF);
    check_eq("sw_imem_dmem", {28'd0, dmem_we}, 32'h0);
    drive(st(3'b010), 32'h2000_0000, 32'hDEAD_BEEF, 32'h0000_0000);
    check_eq("sw_imem_nopc", {28'd0, imem_we}, 32'h0);
    drive(st(3'b010), 32'h3000_0000, 32'hDEAD_BEEF, 32'h4000_0000);
    check_eq("sw_both_d", {28'd0, dmem_we}, 32'hF);
    check_eq("sw_both_i", {28'd0, imem_we}, 32'hF);
    drive(st(3'b010), 32'h1000_0002, 32'hDEAD_BEEF, 32'h0);
    check_eq("sw_mis_dmem", {28'd0, dmem_we}, 32'h0);
    check_eq("sw_mis_flag", {31'd0, misalign}, 32'd1);
    drive(st(3'b010), 32'h8000_0010, 32'hDEAD_BEEF, 32'h4000_0000);
    check_eq("sw_io_d", {28'd0, dmem_we}, 32'h0);
    check_eq("sw_io_i", {28'd0, imem_we}, 32'h0);
    drive(c_NOP, 32'h1000_0000, 32'h0, 32'h0);
    check_eq("nop_dmem", {28'd0, dmem_we}, 32'h0);
    pipe_stall = 1'b1;
    drive(st(3'b000), 32'h1000_0000, 32'h0000_0011, 32'h0);
    check_eq("stall_dmem", {28'd0, dmem_we}, 32'h0);
    pipe_stall = 1'b0;
    idle();

    // Retire counting, suppressed under pipe_stall
    tick();
    check_eq("inst_base", inst_count, 32'd0);
    retire = 1'b1;
    tick(); tick(); tick();
    pipe_stall = 1'b1;
    tick(); tick();
    pipe_stall = 1'b0; retire = 1'b0;
    check_eq("inst_cnt", inst_count, 32'd3);

    // UART TX: back-to-back stores with transmitter not ready
    drive(st(3'b000), 32'h8000_0008, 32'h0000_0041, 32'h0);
    check_eq("tx1_stall", {31'd0, stall_req}, 32'd0);
    check_eq("tx1_dmem",  {28'd0, dmem_we}, 32'h0);
    tick();
    drive(st(3'b000), 32'h8000_0008, 32'h0000_0042, 32'h0);
    check_eq("tx1_valid", {31'd0, uart_tx_valid}, 32'd1);
    check_eq("tx1_data",  {24'd0, uart_tx_data}, 32'h41);
    check_eq("tx2_stall", {31'd0, stall_req}, 32'd1);
    tick();
    check_eq("tx2_hold_data",  {24'd0, uart_tx_data}, 32'h41);
    check_eq("tx2_hold_stall", {31'd0, stall_req}, 32'd1);
    drive(st(3'b010), 32'h8000_0010, 32'h0000_0042, 32'h0);
    check_eq("nontx_nostall", {31'd0, stall_req}, 32'd0);
    drive(st(3'b000), 32'h8000_0008, 32'h0000_0042, 32'h0);
    uart_tx_ready = 1'b1;
    #1;
    check_eq("tx2_ready_stall", {31'd0, stall_req}, 32'd0);
    tick();
    idle(); uart_tx_ready = 1'b0;
    #1;
    check_eq("tx2_valid", {31'd0, uart_tx_valid}, 32'd1);
    check_eq("tx2_data",  {24'd0, uart_tx_data}, 32'h42);
    tick();
    check_eq("tx2_stable", {24'd0, uart_tx_data}, 32'h42);
    uart_tx_ready = 1'b1;
    tick();
    uart_tx_ready = 1'b0;
    check_eq("tx_drain_valid", {31'd0, uart_tx_valid}, 32'd0);
    check_eq("tx_drain_data",  {24'd0, uart_tx_data}, 32'h42);

    // Counter reset at cycle_count=0x1234 with a same-cycle retire
    guard = 0;
    while (cycle_count != 32'h1234 && guard < 8000) begin
      tick();
      guard++;
    end
    check_eq("cyc_reach", cycle_count, 32'h1234);
    drive(st(3'b010), 32'h8000_0018, 32'h0, 32'h0);
    retire = 1'b1;
    tick();
    idle(); retire = 1'b0;
    check_eq("cnt_rst_cyc",  cycle_count, 32'd0);
    check_eq("cnt_rst_inst", inst_count, 32'd0);
    tick();
    check_eq("cnt_after_cyc",  cycle_count, 32'd1);
    check_eq("cnt_after_inst", inst_count, 32'd0);

    // Reset while a byte is pending and counters are non-zero
    retire = 1'b1;
    drive(st(3'b000), 32'h8000_0008, 32'h0000_0055, 32'h0);
    tick();
    idle(); retire = 1'b0;
    check_eq("pre_rst_valid", {31'd0, uart_tx_valid}, 32'd1);
    check_eq("pre_rst_inst",  inst_count, 32'd1);
    rst_n = 1'b0;
    tick();
    check_eq("mid_rst_valid", {31'd0, uart_tx_valid}, 32'd0);
    check_eq("mid_rst_data",  {24'd0, uart_tx_data}, 32'd0);
    check_eq("mid_rst_cyc",   cycle_count, 32'd0);
    check_eq("mid_rst_inst",  inst_count, 32'd0);
    rst_n = 1'b1;

    // 4-bit counters: 20 cycles either wrap to 4 or saturate at 0xF
    for (int i = 0; i < 20; i++) tick();
`ifdef COUNTER_SATURATE_EN
    exp4 = 4'hF;
`else
    exp4 = 4'h4;
`endif
    check_eq("cyc4_20", {28'd0, d4_cycle_count}, {28'd0, exp4});
    check_eq("cyc32_20", cycle_count, 32'd20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/store_mmio_unit.md
Name: store_mmio_unit

Overview:
- Store-side counterpart of the memory-stage load/IO-select control, sitting in the execute stage of the 3-stage RISC-V core.
- Decodes store instructions into byte-lane write enables and lane-aligned write data for DMEM and IMEM.
- Owns the MMIO write side: a one-entry UART TX holding register with valid/ready handshake, plus the cycle and instruction counters that the load path reads back.

Parameters:
- IO_BASE, 4'h8, addr[31:28] value selecting the MMIO space
- CNT_W, 32, width of the cycle and instruction counters

Ports:
- clk  in  1  core clock
- rst_n  in  1  synchronous reset, active-low
- inst_ex  in  32  instruction in execute stage
- addr  in  32  ALU result (effective address)
- rs2_data  in  32  store source data
- pc_ex  in  32  PC of the execute-stage instruction
- pipe_stall  in  1  pipeline frozen; suppresses all writes and side effects
- retire  in  1  one instruction retired this cycle
- dmem_we  out  4  DMEM byte write enables
- imem_we  out  4  IMEM byte write enables
- mem_wdata  out  32  lane-aligned store data, shared by DMEM and IMEM
- uart_tx_data  out  8  byte to UART transmitter
- uart_tx_valid  out  1  TX holding register full
- uart_tx_ready  in  1  transmitter accepts byte
- cycle_count  out  CNT_W  free-running cycle counter
- inst_count  out  CNT_W  retired-instruction counter
- stall_req  out  1  request pipeline stall; store cannot complete this cycle
- misalign  out  1  misaligned SH/SW detected (pulse, combinational)

Behaviour:
Interface facts:
- One clock, clk.
- Reset is synchronous and active-low, port rst_n.

Reset values:
- uart_tx_valid=0, uart_tx_data=0, cycle_count=0, inst_count=0.
- Combinational outputs follow their inputs.

Store qualification:
- A store is active when opcode==STORE and !pipe_stall and !stall_req.

Lane shaping (combinational, same cycle):
- SB: mask=4'b0001<<addr[1:0]; data={4{rs2[7:0]}}.
- SH: mask=4'b0011<<{addr[1],1'b0}; data={2{rs2[15:0]}}. If addr[0]=1: mask=0, misalign=1.
- SW: mask=4'b1111; data=rs2. If addr[1:0]!=0: mask=0, misalign=1.

Address decode:
- addr[31:28]==4'b00x1 -> dmem_we=mask.
- addr[31:28]==4'b001x and pc_ex[30]==1 -> imem_we=mask.
- Both enables may assert together.
- addr[31:28]==IO_BASE -> no memory write.

MMIO writes (word offset addr[7:0], SB/SH/SW all accepted):
- 0x08: UART TX; byte = rs2[7:0].
- 0x18: counter reset.
- Any other offset: ignored.

UART TX FSM, states EMPTY/FULL:
- EMPTY + TX store -> FULL next cycle (uart_tx_valid rises cycle N+1); data latched.
- FULL + valid&ready -> EMPTY, unless a TX store occurs the same cycle, in which case stay FULL with the new byte and no stall.
- FULL + !ready + TX store -> stall_req=1 combinationally; the store retries each cycle until ready.
- uart_tx_data stays stable while valid && !ready.

Counters:
- cycle_count increments every cycle.
- inst_count increments when retire && !pipe_stall.
- Both wrap at 2^CNT_W.
- Counter-reset store: both counters read 0 the next cycle; reset wins over a same-cycle increment.

Reset mid-operation:
- Any pending TX byte is dropped, valid goes 0, counters clear.

stall_req:
- Never asserted for non-TX stores or non-stores.

Optional Feature:
- Macro COUNTER_SATURATE_EN.
- When defined: both counters saturate at all-ones instead of wrapping; a counter-reset store still clears them.
- When undefined: modular wrap.

Decomposition:
- Shared package/header (alongside opcode.vh): MMIO offsets (UART_TX 0x08, CYC 0x10, INST 0x14, CNT_RST 0x18), IO_BASE and region nibble constants, TX FSM state encoding.
- One natural sub-module: store_lane_shaper (combinational mask/data/misalign from funct3, addr[1:0], rs2). The FSM and counters stay in the top module.

Test Plan:
- SB rs2=0xA5 addr=0x10000003 -> dmem_we=4'b1000, mem_wdata=0xA5A5A5A5, imem_we=0.
- SH addr=0x10000001 -> dmem_we=0, misalign=1.
- SW addr=0x20000000 with pc_ex=0x40000000 -> imem_we=4'b1111; same store with pc_ex=0x00000000 -> imem_we=0.
- Two back-to-back TX stores (0x41, 0x42) with uart_tx_ready=0 -> second store holds stall_req=1. Raise ready for one cycle -> 0x41 handshakes, 0x42 latched, valid stays 1, stall_req falls.
- Counter-reset store at cycle_count=0x1234 with retire=1 the same cycle -> both counters read 0 next cycle, then cycle_count=1.
- rst_n=0 while uart_tx_valid=1 and counters non-zero -> next cycle valid=0 and counters 0. With COUNTER_SATURATE_EN and CNT_W=4: 20 cycles -> cycle_count holds 0xF.
